mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) stage and memory (MEM) stage load/store.
- Sequences each access with a req/ack handshake on both sides.
- Returns one-cycle ready pulses that the hazard logic uses to stall: a stage stalls while its req is high and its ready is low.
- Sits between the pipeline datapath and the memory model.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- TIMEOUT_CYCLES, 16, watchdog limit in mem_req cycles; used only with the optional feature; must be >= 2

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request; held with if_addr stable until if_ready
- if_addr  input  ADDR_W  fetch address
- if_rdata  output  DATA_W  fetched word; valid while if_ready=1
- if_ready  output  1  one-cycle completion pulse for fetch
- dm_req  input  1  data request; held with dm_we, dm_addr, dm_wdata stable until dm_ready
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_rdata  output  DATA_W  load data; valid while dm_ready=1
- dm_ready  output  1  one-cycle completion pulse for data
- mem_req  output  1  memory request, held until mem_ack is sampled
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data; valid with mem_ack
- mem_ack  input  1  one-cycle memory completion
- bus_err  output  1  one-cycle timeout error pulse, coincident with the ready pulse

Behaviour:
- All outputs are registered.
- Reset (reset=0) asynchronously forces the following, and abandons any transaction in flight:
  - all outputs to 0
  - state to IDLE
  - last_owner to I
- States:
  - IDLE: no access in progress
  - BUSY: mem_req=1, owner register holds I or D
  - RESP: ready pulse to owner
- Arbitration, evaluated in IDLE and RESP:
  - Candidates are if_req and dm_req.
  - In RESP, the requester currently being answered is masked.
  - Only one pending: grant it.
  - Both pending: grant D unless last_owner=D, then grant I. Both-pending therefore alternates, with no starvation.
- Grant: next state BUSY. The owner's address, we and wdata are captured into mem_addr, mem_we and mem_wdata, and mem_req=1. For an IF grant, mem_we=0.
- In BUSY, request inputs are ignored. On mem_ack=1:
  - next state RESP, mem_req=0
  - last_owner <= owner
  - for a load or fetch, the owner's rdata register <= mem_rdata
- In RESP:
  - The owner's ready=1 for exactly this cycle.
  - A store leaves dm_rdata unchanged.
  - A new grant may occur in this same cycle, so back-to-back accesses are possible.
  - Otherwise next state is IDLE.
- Latency: req sampled at cycle N gives mem_req at N+1. mem_ack at cycle M gives ready at M+1. Minimum latency is 2 cycles plus memory wait states.
- if_rdata and dm_rdata hold their last value between accesses.
- mem_ack in IDLE or RESP is ignored.
- A req dropped before its ready (protocol violation) does not abort a BUSY access; the access completes normally.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in BUSY.
  - If mem_ack has not been sampled after TIMEOUT_CYCLES, go to RESP with mem_req=0 and the owner's rdata=0.
  - The ready pulse and bus_err=1 are asserted together in that RESP cycle.
  - mem_ack arriving on the terminal cycle wins, and no error is raised.
  - The counter clears on every grant.
- Undefined: BUSY waits indefinitely; bus_err is tied to 0.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, RESP}
  - owner enum {OWN_I, OWN_D}
  - default ADDR_W and DATA_W constants
- One sub-module, mem_arb_watchdog:
  - ports: clear, count-enable, TIMEOUT_CYCLES parameter, expired output
  - instantiated only under MEM_ARB_TIMEOUT_EN

Test Plan:
1. Fetch read: if_req=1, if_addr=0x00000004; mem_ack on the 2nd mem_req cycle with mem_rdata=0x20080005.
   - mem_addr=0x4, mem_we=0.
   - if_ready pulses one cycle after the ack, with if_rdata=0x20080005.
   - mem_req is low in that cycle.
2. Collision from IDLE: if_req and dm_req (load, addr 0x100) rise together.
   - Memory serves D first.
   - IF is granted in the D RESP cycle, so mem_req rises again the cycle after dm_ready.
3. Persistent contention: both requests held for 4 accesses with zero-wait acks.
   - Grant order is D, I, D, I.
   - No idle cycle between accesses.
4. Store: dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF.
   - mem_we=1 and mem_wdata=0xDEADBEEF.
   - dm_ready pulses; dm_rdata keeps its prior value.
5. Reset mid-BUSY: assert reset=0 between clock edges.
   - mem_req and all outputs drop to 0 immediately.
   - After release, an idle bus accepts a fresh if_req normally.
6. Timeout: with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, never ack.
   - After 16 BUSY cycles, dm_ready=1 and bus_err=1 together, dm_rdata=0.
   - Without the macro, mem_req stays high for 100 cycles and bus_err=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the IF/MEM memory port arbiter.
//   arb_state_e : arbiter sequencing states (IDLE, BUSY, RESP)
//   owner_e     : which pipeline stage owns the memory access (OWN_I, OWN_D)
//   MEM_ARB_ADDR_W / MEM_ARB_DATA_W : default address / data widths
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_watchdog.sv
// ---------------------------------------------------------------------------
// mem_arb_watchdog
// Counts cycles the arbiter spends waiting on the memory and flags the cycle
// in which the wait reaches TIMEOUT_CYCLES. Only built when MEM_ARB_TIMEOUT_EN
// is defined.
//   clock     : rising-edge clock
//   reset     : asynchronous, active-low reset
//   clear     : restart the count (asserted on every grant)
//   count_en  : high for every cycle spent in BUSY
//   expired   : high during the TIMEOUT_CYCLES-th BUSY cycle
// ---------------------------------------------------------------------------
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  // The count holds 0 .. TIMEOUT_CYCLES-1, so clog2 bits are enough.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count is zero in the first BUSY cycle, so reaching CNT_LAST means
  // this is the TIMEOUT_CYCLES-th cycle without an ack.
  assign expired = count_en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : mem_arb_watchdog

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between the instruction-fetch (IF)
// and data (MEM stage) ports. Each side uses a held req and gets a one-cycle
// ready pulse; the memory side is a req held until a one-cycle ack.
// All outputs are registered.
//
// Optional build macro: MEM_ARB_TIMEOUT_EN
//   defined   : a watchdog ends a BUSY access after TIMEOUT_CYCLES cycles
//               without ack, returning rdata=0 with bus_err pulsed alongside
//               the ready pulse.
//   undefined : BUSY waits for mem_ack indefinitely, bus_err stays 0.
//
// Ports
//   clock, reset                   : clock, asynchronous active-low reset
//   if_req/if_addr                 : fetch request (held until if_ready)
//   if_rdata/if_ready              : fetched word + one-cycle completion
//   dm_req/dm_we/dm_addr/dm_wdata  : load/store request (held until dm_ready)
//   dm_rdata/dm_ready              : load data + one-cycle completion
//   mem_req/mem_we/mem_addr/mem_wdata : memory request side
//   mem_rdata/mem_ack              : memory response side
//   bus_err                        : timeout pulse, coincident with ready
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W         = MEM_ARB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              bus_err_q, bus_err_d;

  logic              grant;
  logic              cand_i, cand_d, pick_d;
  logic              wd_expired;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (grant),
    .count_en (state_q == BUSY),
    .expired  (wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 2);
  assign wd_expired         = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;
    bus_err_d    = 1'b0;
    grant        = 1'b0;
    cand_i       = 1'b0;
    cand_d       = 1'b0;
    pick_d       = 1'b0;

    case (state_q)
      BUSY: begin
        // Request inputs are ignored here; only the memory can end the access.
        if (mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          last_owner_d = owner_q;
          if (owner_q == OWN_I) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            // A store leaves the load data register untouched.
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
            dm_ready_d = 1'b1;
          end
        end else if (wd_expired) begin
          // Abandoned access still counts as served for fairness.
          state_d      = RESP;
          mem_req_d    = 1'b0;
          last_owner_d = owner_q;
          bus_err_d    = 1'b1;
          if (owner_q == OWN_I) begin
            if_rdata_d = '0;
            if_ready_d = 1'b1;
          end else begin
            dm_rdata_d = '0;
            dm_ready_d = 1'b1;
          end
        end
      end

      default: begin
        // IDLE and RESP arbitrate. In RESP the side being answered is masked:
        // its req is still high during its own ready cycle.
        cand_i = if_req && !((state_q == RESP) && (owner_q == OWN_I));
        cand_d = dm_req && !((state_q == RESP) && (owner_q == OWN_D));
        pick_d = cand_d && (!cand_i || (last_owner_q != OWN_D));

        if (cand_i || cand_d) begin
          grant     = 1'b1;
          state_d   = BUSY;
          mem_req_d = 1'b1;
          if (pick_d) begin
            owner_d     = OWN_D;
            mem_addr_d  = dm_addr;
            mem_we_d    = dm_we;
            mem_wdata_d = dm_wdata;
          end else begin
            // Fetches never write; mem_wdata is left as it was.
            owner_d    = OWN_I;
            mem_addr_d = if_addr;
            mem_we_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign bus_err   = bus_err_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives the IF and data ports plus a small memory responder, and compares
// every cycle against a transaction-level reference model. Honors the
// MEM_ARB_TIMEOUT_EN build macro for the timeout scenario.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          bus_err;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_err   (bus_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // m_busy : an access is outstanding on the memory bus
  // m_resp : requester being answered this cycle (-1 none, 0 IF, 1 DM)
  // m_last : requester served most recently (0 IF, 1 DM)
  bit          m_busy;
  int          m_owner, m_resp, m_last, m_cnt;
  logic [31:0] m_addr, m_wdata;
  bit          m_we;
  logic [31:0] exp_if_rdata, exp_dm_rdata;
  bit          exp_if_ready, exp_dm_ready, exp_bus_err;
  logic [31:0] ref_mem  [16];
  logic [31:0] resp_mem [16];
  int          wait_mode;   // -1 random 0..3, -2 never ack, else fixed wait
  int          wait_left;
  bit          idle_glitch;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_resp = -1; m_last = 0; m_cnt = 0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    exp_if_ready = 0; exp_dm_ready = 0; exp_bus_err = 0;
  endtask

  task automatic model_finish(input bit timeout);
    logic [3:0] idx;
    idx = m_addr[5:2];
    m_busy = 0;
    m_resp = m_owner;
    m_last = m_owner;
    exp_bus_err = timeout;
    if (m_owner == 0) begin
      exp_if_ready = 1;
      exp_if_rdata = timeout ? 32'h0 : ref_mem[idx];
    end else begin
      exp_dm_ready = 1;
      if (timeout) exp_dm_rdata = 32'h0;
      else if (m_we) ref_mem[idx] = m_wdata;
      else exp_dm_rdata = ref_mem[idx];
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int  prev_resp;
    bit  ci, cd;
    prev_resp = m_resp;
    exp_if_ready = 0; exp_dm_ready = 0; exp_bus_err = 0;
    if (m_busy) begin
      m_cnt++;
      if (mem_ack) model_finish(1'b0);
      else if (TO_EN && m_cnt >= TO) model_finish(1'b1);
    end else begin
      ci = if_req && (prev_resp != 0);
      cd = dm_req && (prev_resp != 1);
      m_resp = -1;
      if (ci || cd) begin
        m_busy = 1;
        m_cnt  = 0;
        wait_left = (wait_mode == -1) ? int'($urandom_range(0, 3)) : wait_mode;
        if (cd && (!ci || m_last != 1)) begin
          m_owner = 1; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
        end else begin
          m_owner = 0; m_addr = if_addr; m_we = 0;
        end
      end
    end
  endtask

  // Memory responder: serves the bus from its own array using the DUT's bus.
  task automatic drive_mem();
    if (m_busy) begin
      if (wait_mode == -2) begin
        mem_ack = 0; mem_rdata = $urandom;
      end else if (wait_left == 0) begin
        mem_ack = 1;
        mem_rdata = resp_mem[mem_addr[5:2]];
        if (mem_we) resp_mem[mem_addr[5:2]] = mem_wdata;
      end else begin
        wait_left--; mem_ack = 0; mem_rdata = $urandom;
      end
    end else begin
      mem_ack = idle_glitch && ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  endtask

  task automatic compare();
    check_val("mem_req", mem_req, m_busy);
    if (m_busy) begin
      check_val("mem_addr", mem_addr, m_addr);
      check_val("mem_we", mem_we, m_we);
      if (m_we) check_val("mem_wdata", mem_wdata, m_wdata);
    end
    check_val("if_ready", if_ready, exp_if_ready);
    check_val("dm_ready", dm_ready, exp_dm_ready);
    check_val("bus_err", bus_err, exp_bus_err);
    check_val("if_rdata", if_rdata, exp_if_rdata);
    check_val("dm_rdata", dm_rdata, exp_dm_rdata);
  endtask

  task automatic cycle();
    drive_mem();
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare();
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [3:0] r;
    r = 4'($urandom);
    return {26'd0, r, 2'b00};
  endfunction

  task automatic rnd_reqs();
    if (if_req) begin
      if (exp_if_ready) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = rnd_addr();
      end
    end else if ($urandom_range(0, 2) == 0) begin
      if_req = 1; if_addr = rnd_addr();
    end
    if (dm_req) begin
      if (exp_dm_ready) begin
        dm_req = ($urandom_range(0, 3) != 0);
        dm_addr = rnd_addr(); dm_we = 1'($urandom); dm_wdata = $urandom;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      dm_req = 1; dm_addr = rnd_addr(); dm_we = 1'($urandom); dm_wdata = $urandom;
    end
  endtask

  int          owners[$];
  int          pulse_at[$];
  logic        req_at  [8];
  logic [31:0] addr_at [8];
  logic [31:0] saved;
  int          n_pulse;

  initial begin
    model_reset();
    wait_mode = -1;
    idle_glitch = 0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]  = 32'h1000_0000 + 32'(i) * 32'h111;
      resp_mem[i] = ref_mem[i];
    end

    // Reset state
    repeat (3) @(negedge clock);
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_if_ready", if_ready, 0);
    check_val("rst_dm_ready", dm_ready, 0);
    check_val("rst_bus_err", bus_err, 0);
    check_val("rst_if_rdata", if_rdata, 0);
    reset = 1;

    // 1: fetch read, ack on 2nd mem_req cycle
    ref_mem[1] = 32'h2008_0005; resp_mem[1] = 32'h2008_0005;
    wait_mode = 1;
    if_req = 1; if_addr = 32'h4;
    cycle();
    check_val("t1_mem_addr", mem_addr, 32'h4);
    check_val("t1_mem_we", mem_we, 0);
    cycle();
    cycle();
    check_val("t1_if_ready", if_ready, 1);
    check_val("t1_if_rdata", if_rdata, 32'h2008_0005);
    check_val("t1_mem_req_low", mem_req, 0);
    if_req = 0;
    cycle();

    // 2+3: collision from IDLE, then persistent contention with zero waits
    wait_mode = 0;
    if_req = 1; if_addr = 32'h8;
    dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    for (int k = 0; k < 8; k++) begin
      cycle();
      req_at[k] = mem_req;
      addr_at[k] = mem_addr;
      if (dm_ready) begin owners.push_back(1); pulse_at.push_back(k); end
      if (if_ready) begin owners.push_back(0); pulse_at.push_back(k); end
    end
    if_req = 0; dm_req = 0;
    cycle();
    check_val("t2_regrant_req", req_at[2], 1);
    check_val("t2_regrant_addr", addr_at[2], 32'h8);
    check_val("t3_n_access", owners.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check_val("t3_owner", (k < owners.size()) ? owners[k] : -1, (k % 2 == 0) ? 1 : 0);
      check_val("t3_pulse_cycle", (k < pulse_at.size()) ? pulse_at[k] : -1, 2 * k + 1);
    end

    // 4: store keeps dm_rdata, then load it back
    saved = ref_mem[0];
    dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
    cycle();
    check_val("t4_mem_we", mem_we, 1);
    check_val("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cycle();
    check_val("t4_dm_ready", dm_ready, 1);
    check_val("t4_dm_rdata_kept", dm_rdata, saved);
    dm_req = 0; dm_we = 0;
    cycle();
    dm_req = 1; dm_we = 0; dm_addr = 32'h10;
    cycle();
    cycle();
    check_val("t4_readback", dm_rdata, 32'hDEAD_BEEF);
    dm_req = 0;
    cycle();

    // Randomized traffic with random wait states and stray idle acks
    wait_mode = -1; idle_glitch = 1;
    repeat (1500) begin
      cycle();
      rnd_reqs();
    end
    if_req = 0; dm_req = 0;
    repeat (8) cycle();
    idle_glitch = 0;

    // 6: no ack
    dm_req = 1; dm_we = 0; dm_addr = 32'h20; wait_mode = -2;
`ifdef MEM_ARB_TIMEOUT_EN
    n_pulse = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (dm_ready) begin
        n_pulse++;
        check_val("t6_timeout_cycle", k, 16);
        check_val("t6_bus_err", bus_err, 1);
        check_val("t6_rdata_zero", dm_rdata, 0);
        dm_req = 0;
      end
    end
    check_val("t6_n_timeout", n_pulse, 1);
    // ack exactly on the terminal cycle wins over the watchdog
    dm_req = 1; dm_we = 0; dm_addr = 32'h20; wait_mode = 15;
    n_pulse = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (dm_ready) begin
        n_pulse++;
        check_val("t6_term_cycle", k, 16);
        check_val("t6_term_no_err", bus_err, 0);
        check_val("t6_term_rdata", dm_rdata, ref_mem[8]);
        dm_req = 0;
      end
    end
    check_val("t6_n_term", n_pulse, 1);
    dm_req = 1; dm_addr = 32'h24; wait_mode = -2;
    repeat (3) cycle();
`else
    repeat (100) cycle();
    check_val("t6_req_held", mem_req, 1);
    check_val("t6_no_err", bus_err, 0);
`endif

    // 5: asynchronous reset in the middle of a BUSY access
    check_val("t5_busy_before", mem_req, 1);
    mem_ack = 0;
    #2;
    reset = 0;
    #1;
    check_val("t5_mem_req", mem_req, 0);
    check_val("t5_mem_we", mem_we, 0);
    check_val("t5_mem_addr", mem_addr, 0);
    check_val("t5_mem_wdata", mem_wdata, 0);
    check_val("t5_if_rdata", if_rdata, 0);
    check_val("t5_dm_rdata", dm_rdata, 0);
    check_val("t5_if_ready", if_ready, 0);
    check_val("t5_dm_ready", dm_ready, 0);
    check_val("t5_bus_err", bus_err, 0);
    model_reset();
    dm_req = 0;
    @(negedge clock);
    reset = 1;
    wait_mode = 0;
    if_req = 1; if_addr = 32'h4;
    cycle();
    check_val("t5_fresh_req", mem_req, 1);
    check_val("t5_fresh_addr", mem_addr, 32'h4);
    cycle();
    check_val("t5_fresh_ready", if_ready, 1);
    check_val("t5_fresh_rdata", if_rdata, ref_mem[1]);
    if_req = 0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mem_port_arbiter
